// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX->MEM pipeline register with valid/ready handshake and 1-entry skid buffer
//
// Holds the EX result while the data cache misses without losing an upstream
// beat, turns queued entries into bubbles on flush, and counts stall cycles.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             discard main and skid entries next cycle
//   data_hit          MEM side ready (0 = cache miss, hold the output entry)
//   in_valid/in_ready EX-side handshake; in_ready depends only on skid_full
//   ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdata2, muxout
//                     EX beat fields
//   out_valid         MEM-side entry valid
//   wb_ctlout, m_ctlout
//                     registered control, gated to 0 when !out_valid
//   add_result, zero, alu_result, rdata2out, five_bit_muxout
//                     registered beat fields
//   skid_full         skid entry occupied
//   stall_cnt         saturating count of cycles held on a miss
module ex_mem_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              data_hit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   ctlwb_out,
    input  logic [M_W-1:0]    ctlm_out,
    input  logic [ADDR_W-1:0] adder_out,
    input  logic              aluzero,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] readdata2,
    input  logic [REG_W-1:0]  muxout,
    output logic              out_valid,
    output logic [WB_W-1:0]   wb_ctlout,
    output logic [M_W-1:0]    m_ctlout,
    output logic [ADDR_W-1:0] add_result,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_W-1:0]  five_bit_muxout,
    output logic              skid_full,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BEAT_W = WB_W + M_W + ADDR_W + 1 + 2 * DATA_W + REG_W;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_q;
    logic [BEAT_W-1:0] skid_q;
    logic [WB_W-1:0]   wb_q;
    logic [M_W-1:0]    m_q;
    logic              accept;
    logic              main_free;
    logic              stalled;

    assign in_beat = {ctlwb_out, ctlm_out, adder_out, aluzero, aluout, readdata2, muxout};

    // in_ready comes straight from a register so there is no combinational
    // path from data_hit back into the EX stage.
    assign in_ready  = !skid_full;
    assign accept    = in_valid && in_ready;
    // Main entry can be (re)loaded this cycle: it is empty or being consumed.
    assign main_free = !out_valid || data_hit;
    assign stalled   = out_valid && !data_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            // Data registers keep stale contents; the valid bits alone make
            // them bubbles, and the control gating below hides them.
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (main_free) begin
            if (skid_full) begin
                // Older skid beat goes first to preserve order.
                main_q    <= skid_q;
                out_valid <= 1'b1;
                skid_full <= accept;
                if (accept) begin
                    skid_q <= in_beat;
                end
            end else if (accept) begin
                main_q    <= in_beat;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main held on a miss: park the incoming beat in the skid slot.
            skid_q    <= in_beat;
            skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign {wb_q, m_q, add_result, zero, alu_result, rdata2out, five_bit_muxout} = main_q;

    // A bubble must never write a register or memory.
    assign wb_ctlout = wb_q & {WB_W{out_valid}};
    assign m_ctlout  = m_q & {M_W{out_valid}};

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - directed self-checking bench for ex_mem_stage_reg
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, data_hit, in_valid;
    logic [1:0]  ctlwb_out;
    logic [2:0]  ctlm_out;
    logic [29:0] adder_out;
    logic        aluzero;
    logic [31:0] aluout, readdata2;
    logic [4:0]  muxout;

    logic        in_ready, out_valid, zero, skid_full;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [29:0] add_result;
    logic [31:0] alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_zero, s_skid_full;
    logic [1:0]  s_wb_ctlout;
    logic [2:0]  s_m_ctlout;
    logic [29:0] s_add_result;
    logic [31:0] s_alu_result, s_rdata2out;
    logic [4:0]  s_five_bit_muxout;
    logic [1:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .data_hit(data_hit),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
        .aluzero(aluzero), .aluout(aluout), .readdata2(readdata2), .muxout(muxout),
        .out_valid(out_valid), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
        .skid_full(skid_full), .stall_cnt(stall_cnt)
    );

    ex_mem_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .data_hit(data_hit),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .adder_out(adder_out),
        .aluzero(aluzero), .aluout(aluout), .readdata2(readdata2), .muxout(muxout),
        .out_valid(s_out_valid), .wb_ctlout(s_wb_ctlout), .m_ctlout(s_m_ctlout),
        .add_result(s_add_result), .zero(s_zero), .alu_result(s_alu_result),
        .rdata2out(s_rdata2out), .five_bit_muxout(s_five_bit_muxout),
        .skid_full(s_skid_full), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; data_hit = 1'b1; in_valid = 1'b0;
        ctlwb_out = 2'd1; ctlm_out = 3'd2; adder_out = 30'h123; aluzero = 1'b1;
        aluout = 32'd0; readdata2 = 32'hdead; muxout = 5'd7;

        // 1: reset
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_wb", wb_ctlout, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_skid", skid_full, 0);
        check("rst_alu", alu_result, 0);

        // 2: streaming, 1-cycle latency, 1 beat/cycle
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aluout = 32'd10 + 32'(i);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_alu", alu_result, 64'd10 + 64'(i));
        end
        check("stream_wb", wb_ctlout, 1);
        check("stream_rd", five_bit_muxout, 7);
        in_valid = 1'b0;
        step();
        check("stream_drain", out_valid, 0);
        check("stream_stall", stall_cnt, 0);

        // 3: A held on miss, B into skid, C refused
        in_valid = 1'b1; aluout = 32'd10;
        step();
        check("a_loaded", alu_result, 10);
        data_hit = 1'b0; aluout = 32'd20;
        step();
        check("b_skid_full", skid_full, 1);
        check("b_in_ready", in_ready, 0);
        aluout = 32'd30;
        step(); step();
        check("hold_alu", alu_result, 10);
        check("hold_stall3", stall_cnt, 3);
        check("hold_skid", skid_full, 1);
        data_hit = 1'b1; in_valid = 1'b0;
        step();
        check("b_out_alu", alu_result, 20);
        check("b_out_valid", out_valid, 1);
        check("b_skid_empty", skid_full, 0);
        step();
        check("ab_drained", out_valid, 0);
        check("ab_stall", stall_cnt, 3);

        // 4: flush with main and skid full
        in_valid = 1'b1; aluout = 32'd40; ctlwb_out = 2'd2; ctlm_out = 3'd4;
        step();
        check("ctl_pass_wb", wb_ctlout, 2);
        check("ctl_pass_m", m_ctlout, 4);
        data_hit = 1'b0; aluout = 32'd50;
        step();
        check("fl_skid_full", skid_full, 1);
        flush = 1'b1; aluout = 32'd60;
        step();
        check("fl_valid", out_valid, 0);
        check("fl_skid", skid_full, 0);
        check("fl_wb", wb_ctlout, 0);
        check("fl_m", m_ctlout, 0);
        check("fl_stall", stall_cnt, 5);
        check("fl_sat_stall", s_stall_cnt, 3);
        // flush drops a beat accepted in the same cycle
        data_hit = 1'b1; aluout = 32'd70;
        step();
        check("fl_drop_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_no_ghost", out_valid, 0);

        // 5: bubble gating
        check("bub_wb", wb_ctlout, 0);
        check("bub_m", m_ctlout, 0);

        // 6: saturation with CNT_W=2, then reset during a stall
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b1; aluout = 32'd5;
        step();
        in_valid = 1'b0; data_hit = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt", s_stall_cnt, 3);
        check("sat_wide_cnt", stall_cnt, 5);
        check("sat_valid", s_out_valid, 1);
        rst = 1'b1;
        step();
        check("rst2_stall", stall_cnt, 0);
        check("rst2_sat", s_stall_cnt, 0);
        check("rst2_valid", out_valid, 0);
        check("rst2_alu", alu_result, 0);
        // miss while empty: no stall counted
        rst = 1'b0;
        step(); step();
        check("idle_miss_stall", stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
